// File: rtl/fp_alu_result_stage.sv
// Control/writeback stage around the FP ALU 15:1 result mux: sequences one op at a time,
// starts and waits for multi-cycle units, and registers the result onto a valid/ready port.
module fp_alu_result_stage #(
    parameter int unsigned WIDTH   = 64,
    parameter logic [14:0] MC_MASK = 15'h0060,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_sel,
    output logic             mc_start,
    input  logic             mc_done,
    output logic [3:0]       mux_s,
    input  logic [WIDTH-1:0] mux_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_sel,
    output logic             res_err
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitMc,
        StResp
    } state_e;

    // Source 15 does not exist; padding the mask keeps the index in range for 4'hF.
    localparam logic [15:0]      MC_MASK_EXT = {1'b0, MC_MASK};
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [3:0]         mux_s_q, mux_s_d;
    logic [3:0]         res_sel_q, res_sel_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic               res_valid_q, res_valid_d;
    logic               mc_start_q, mc_start_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        mux_s_d     = mux_s_q;
        res_sel_d   = res_sel_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        mc_start_d  = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    mux_s_d   = op_sel;
                    res_sel_d = op_sel;
                    if (op_sel == 4'hF) begin
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = StResp;
                    end else if (MC_MASK_EXT[op_sel]) begin
                        mc_start_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = StWaitMc;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                res_data_d  = mux_x;
                res_err_d   = 1'b0;
                res_valid_d = 1'b1;
                state_d     = StResp;
            end
            StWaitMc: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the timeout edge still counts as a normal completion.
                if (mc_done) begin
                    res_data_d  = mux_x;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (cnt_q == WAIT_LAST) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mux_s_q     <= '0;
            res_sel_q   <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            mc_start_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mux_s_q     <= mux_s_d;
            res_sel_q   <= res_sel_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            mc_start_q  <= mc_start_d;
            cnt_q       <= cnt_d;
        end
    end

    assign op_ready  = (state_q == StIdle);
    assign mc_start  = mc_start_q;
    assign mux_s     = mux_s_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign res_err   = res_err_q;

endmodule
